// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared types and constants for the parametrised serial pattern detector.
//   - state_t     : detector FSM states (history filling / running compare)
//   - CW_DEFAULT  : default match-counter width
//   - SAT_DEFAULT : saturation value of a counter of the default width
package seq_det_pkg;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int          CW_DEFAULT  = 8;
    localparam int unsigned SAT_DEFAULT = (1 << CW_DEFAULT) - 1;

endpackage

// File: rtl/seq_detector_n_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous active-high reset (q -> 0)
//     clr  in   synchronous clear, wins over inc
//     inc  in   increment request; ignored once q is all ones
//     q    out  CW-bit count
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    logic [CW-1:0] q_q;
    logic [CW-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {CW{1'b1}})) begin
            q_d = q_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_detector_n.sv
// seq_detector_n
//   Serial pattern detector: one bit of w is taken per en=1 cycle and the last
//   N bits are compared against a runtime-loadable pattern. A match produces a
//   registered one-cycle pulse on z and bumps a saturating counter.
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset
//     en         in   sample strobe for w
//     w          in   serial data bit
//     load       in   pattern load strobe (priority over en)
//     pat_in     in   N-bit pattern captured on load
//     overlap    in   1 = keep history after a match, 0 = restart fill
//     count_clr  in   synchronous clear of the match counter
//     z          out  registered match pulse
//     count      out  saturating match count
//     armed      out  1 while a full N-bit history is held
module seq_detector_n
    import seq_det_pkg::*;
#(
    parameter int           N       = 3,
    parameter logic [N-1:0] PATTERN = 3'b101,
    parameter int           CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          w,
    input  logic          load,
    input  logic [N-1:0]  pat_in,
    input  logic          overlap,
    input  logic          count_clr,
    output logic          z,
    output logic [CW-1:0] count,
    output logic          armed
);

    localparam int           FW        = $clog2(N);
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

    logic [N-1:0]  pat_q,  pat_d;
    logic [N-1:0]  hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;
    state_t        state_q, state_d;
    logic          z_q,    z_d;

    logic [N-1:0]  cand;
    logic          match;

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        match   = 1'b0;
        cand    = {hist_q[N-2:0], w};

        if (load) begin
            // The w bit presented alongside load is deliberately dropped.
            pat_d   = pat_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_FILL;
        end else if (en) begin
            hist_d = cand;
            if (state_q == S_FILL) begin
                if (fill_q == FILL_LAST) begin
                    // This bit completes the history, so compare right away.
                    match   = (cand == pat_q);
                    state_d = S_RUN;
                end else begin
                    fill_d = fill_q + FW'(1);
                end
            end else begin
                match = (cand == pat_q);
            end

            if (match && !overlap) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = S_FILL;
            end
        end

        z_d = match;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= PATTERN;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= S_FILL;
            z_q     <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    sat_counter #(
        .CW (CW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (count_clr),
        .inc (match),
        .q   (count)
    );

    assign z     = z_q;
    assign armed = (state_q == S_RUN);

endmodule

// File: tb/tb_seq_detector_n.sv
// tb_seq_detector_n
//   Directed bench for seq_detector_n. Two instances share the stimulus:
//   u_dut (N=3, PATTERN=101, CW=8) and u_sat (N=3, PATTERN=111, CW=2) for
//   the saturation scenario.
module tb_seq_detector_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       w = 1'b0;
    logic       load = 1'b0;
    logic [2:0] pat_in = 3'b000;
    logic       overlap = 1'b1;
    logic       count_clr = 1'b0;

    logic       z1, armed1;
    logic [7:0] count1;
    logic       z2, armed2;
    logic [1:0] count2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    seq_detector_n #(.N(3), .PATTERN(3'b101), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .w(w), .load(load), .pat_in(pat_in),
        .overlap(overlap), .count_clr(count_clr),
        .z(z1), .count(count1), .armed(armed1)
    );

    seq_detector_n #(.N(3), .PATTERN(3'b111), .CW(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .w(w), .load(load), .pat_in(pat_in),
        .overlap(overlap), .count_clr(count_clr),
        .z(z2), .count(count2), .armed(armed2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; count_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Present one enabled bit and let it be sampled.
    task automatic shift(input logic b);
        en = 1'b1; w = b;
        tick();
        en = 1'b0;
    endtask

    logic [4:0] s5;
    logic [4:0] z_ov;
    logic [4:0] z_nov;
    logic [5:0] z_sat;
    logic [1:0] c_sat [6];

    initial begin
        s5    = 5'b10101;
        z_ov  = 5'b00101;
        z_nov = 5'b00100;
        z_sat = 6'b001111;
        c_sat = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

        // Reset state
        do_reset();
        chk("rst_z", z1, 0);
        chk("rst_count", count1, 0);
        chk("rst_armed", armed1, 0);

        // Overlapping 1,0,1,0,1
        overlap = 1'b1;
        for (int i = 0; i < 5; i++) begin
            shift(s5[4-i]);
            chk($sformatf("ov_z%0d", i), z1, z_ov[4-i]);
            if (i == 1) chk("ov_armed_pre", armed1, 0);
            if (i == 2) chk("ov_armed", armed1, 1);
        end
        chk("ov_count", count1, 2);
        tick();
        chk("ov_z_idle", z1, 0);

        // Non-overlapping 1,0,1,0,1
        do_reset();
        overlap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            shift(s5[4-i]);
            chk($sformatf("nov_z%0d", i), z1, z_nov[4-i]);
            if (i == 2) chk("nov_armed", armed1, 0);
        end
        chk("nov_count", count1, 1);

        // Gap of en=0 inside a pattern
        do_reset();
        overlap = 1'b1;
        shift(1'b1);
        shift(1'b0);
        for (int i = 0; i < 3; i++) begin
            w = 1'b1;
            tick();
            chk($sformatf("gap_z%0d", i), z1, 0);
        end
        chk("gap_armed", armed1, 0);
        shift(1'b1);
        chk("gap_hit", z1, 1);
        tick();
        chk("gap_after", z1, 0);

        // Load mid-stream: loaded-cycle bit discarded, history cleared
        do_reset();
        shift(1'b1);
        shift(1'b1);
        load = 1'b1; pat_in = 3'b110; en = 1'b1; w = 1'b1;
        tick();
        load = 1'b0; en = 1'b0;
        chk("ld_z", z1, 0);
        chk("ld_armed", armed1, 0);
        shift(1'b1);
        chk("ld_z0", z1, 0);
        shift(1'b1);
        chk("ld_z1", z1, 0);
        chk("ld_armed1", armed1, 0);
        shift(1'b0);
        chk("ld_z2", z1, 1);
        chk("ld_count", count1, 1);

        // Saturation with CW=2 on all-ones stream
        do_reset();
        overlap = 1'b1;
        for (int i = 0; i < 6; i++) begin
            shift(1'b1);
            chk($sformatf("sat_z%0d", i), z2, z_sat[5-i]);
            chk($sformatf("sat_cnt%0d", i), count2, c_sat[i]);
        end
        count_clr = 1'b1;
        shift(1'b1);
        count_clr = 1'b0;
        chk("clr_z", z2, 1);
        chk("clr_count", count2, 0);
        shift(1'b1);
        chk("clr_next", count2, 1);

        // Mid-stream reset after a custom pattern, with a match pending
        do_reset();
        load = 1'b1; pat_in = 3'b011;
        tick();
        load = 1'b0;
        shift(1'b0);
        shift(1'b1);
        rst = 1'b1; en = 1'b1; w = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        chk("mrst_z", z1, 0);
        chk("mrst_count", count1, 0);
        chk("mrst_armed", armed1, 0);
        shift(1'b1);
        shift(1'b0);
        chk("mrst_z_pre", z1, 0);
        shift(1'b1);
        chk("mrst_default", z1, 1);
        chk("mrst_count1", count1, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
